montgomery_reduce_stream: RTL and testbench



---
 rtl/montgomery_reduce_stream_pkg.sv | 18 +
 rtl/mont_pipe_mul.sv | 22 ++
 rtl/montgomery_reduce_stream.sv | 115 +++++++++++
 tb/tb_montgomery_reduce_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_reduce_stream_pkg.sv
// Shared defaults, latency helper and sideband layout for the Montgomery reduction stream.
package mont_pkg;
  localparam int MONT_DATA_W     = 64;
  localparam int MONT_MUL_STAGES = 3;
  localparam int MONT_BL_W       = $clog2(MONT_DATA_W + 1);

  typedef struct packed {
    logic [MONT_DATA_W-1:0] q;
    logic [MONT_DATA_W-1:0] qinv;
    logic [MONT_BL_W-1:0]   q_bl;
    logic                   err;
  } mont_side_t;

  // S0 + multiplier A + S2 + multiplier B + S4 + S5
  function automatic int mont_lat(input int mul_stages);
    return 2 * mul_stages + 4;
  endfunction
endpackage

// File: rtl/mont_pipe_mul.sv
// Enable-gated pipelined multiplier: product appears MUL_STAGES enabled clocks after its operands.
module mont_pipe_mul #(
  parameter int DATA_W     = 64,
  parameter int MUL_STAGES = 3
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic [2*DATA_W-1:0]   p_o
);
  logic [MUL_STAGES-1:0][2*DATA_W-1:0] p_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      p_q[0] <= (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
      for (int i = 1; i < MUL_STAGES; i++) p_q[i] <= p_q[i-1];
    end
  end

  assign p_o = p_q[MUL_STAGES-1];
endmodule

// File: rtl/montgomery_reduce_stream.sv
// Fully pipelined Montgomery reduction x*2^-q_bl mod q with per-beat modulus and global-stall backpressure.
// Optional per-beat tag passthrough when MONTGOMERY_TAG_EN is defined.
module montgomery_reduce_stream
  import mont_pkg::*;
#(
  parameter int DATA_W     = MONT_DATA_W,
  parameter int MUL_STAGES = MONT_MUL_STAGES,
  parameter int BL_W       = $clog2(DATA_W + 1)
`ifdef MONTGOMERY_TAG_EN
  , parameter int TAG_W    = 8
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2*DATA_W-1:0]   x_i,
  input  logic [DATA_W-1:0]     q_i,
  input  logic [DATA_W-1:0]     qinv_i,
  input  logic [BL_W-1:0]       q_bl_i,
`ifdef MONTGOMERY_TAG_EN
  input  logic [TAG_W-1:0]      tag_i,
  output logic [TAG_W-1:0]      tag_o,
`endif
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_W-1:0]     result_o,
  output logic                  err_o
);
  localparam int LAT    = mont_lat(MUL_STAGES);
  localparam int STAGES = LAT - 1;
  localparam int XD     = 2 * MUL_STAGES + 3;   // beat delay slots p0 .. p(2M+2)
  localparam int PM     = MUL_STAGES;           // slot aligned with multiplier A output
  localparam int PB     = 2 * MUL_STAGES + 1;   // slot aligned with multiplier B output

  typedef struct packed {
    logic [2*DATA_W-1:0] x;
    logic [DATA_W-1:0]   q;
    logic [DATA_W-1:0]   qinv;
    logic [BL_W-1:0]     q_bl;
    logic                err;
  } beat_t;

  // Low q_bl bits set; one spare bit keeps q_bl == DATA_W from overflowing the shift.
  function automatic logic [DATA_W-1:0] low_mask(input logic [BL_W-1:0] bl);
    return DATA_W'(~({(DATA_W+1){1'b1}} << bl));
  endfunction

  logic                    adv, accept;
  logic [STAGES:0]         vld_pipe;
  beat_t [XD-1:0]          beat_q;
  logic [DATA_W-1:0]       lsb_q, m_q;
  logic [DATA_W:0]         t_q, t_sub;
  logic [2*DATA_W-1:0]     prod_a, prod_b;
  logic [2*DATA_W:0]       sum_d;
  logic [DATA_W-1:0]       res_d;
  logic                    in_err;

  assign adv     = !valid_o || ready_i;
  assign ready_o = adv;
  assign accept  = valid_i && adv;
  assign valid_o = vld_pipe[STAGES];
  assign in_err  = (q_bl_i == '0) || (q_bl_i > BL_W'(DATA_W));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:0], accept};
  end

  mont_pipe_mul #(.DATA_W(DATA_W), .MUL_STAGES(MUL_STAGES)) u_mul_a (
    .clk_i (clk_i), .en_i (adv), .a_i (lsb_q), .b_i (beat_q[0].qinv), .p_o (prod_a)
  );

  mont_pipe_mul #(.DATA_W(DATA_W), .MUL_STAGES(MUL_STAGES)) u_mul_b (
    .clk_i (clk_i), .en_i (adv), .a_i (m_q), .b_i (beat_q[PM+1].q), .p_o (prod_b)
  );

  // 2*DATA_W+1 bit sum so the carry of x + m*q survives the shift
  assign sum_d = {1'b0, beat_q[PB].x} + {1'b0, prod_b};
  assign t_sub = t_q - {1'b0, beat_q[XD-1].q};
  assign res_d = beat_q[XD-1].err ? '0
               : (t_sub[DATA_W] ? t_q[DATA_W-1:0] : t_sub[DATA_W-1:0]);

  always_ff @(posedge clk_i) begin
    if (adv) begin
      beat_q[0] <= '{x: x_i, q: q_i, qinv: qinv_i, q_bl: q_bl_i, err: in_err};
      lsb_q     <= x_i[DATA_W-1:0] & low_mask(q_bl_i);
      for (int i = 1; i < XD; i++) beat_q[i] <= beat_q[i-1];
      m_q       <= DATA_W'(prod_a) & low_mask(beat_q[PM].q_bl);
      t_q       <= (DATA_W+1)'(sum_d >> beat_q[PB].q_bl);
    end
  end

  // Output only updates on a live beat so it holds through stalls and bubbles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
      err_o    <= 1'b0;
    end else if (adv && vld_pipe[STAGES-1]) begin
      result_o <= res_d;
      err_o    <= beat_q[XD-1].err;
    end
  end

`ifdef MONTGOMERY_TAG_EN
  logic [STAGES:0][TAG_W-1:0] tag_pipe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tag_pipe <= '0;
    else if (adv) tag_pipe <= {tag_pipe[STAGES-1:0], tag_i};
  end

  assign tag_o = tag_pipe[STAGES];
`endif
endmodule

// File: tb/tb_montgomery_reduce_stream.sv
// Directed and reference-model checks for montgomery_reduce_stream at DATA_W=64, MUL_STAGES=3.
module tb_montgomery_reduce_stream;
  import mont_pkg::*;
  localparam int DW  = 64;
  localparam int LAT = mont_lat(3);

  logic            clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic            ready_o, valid_o, err_o;
  logic [2*DW-1:0] x_i = '0;
  logic [DW-1:0]   q_i = '0, qinv_i = '0, result_o;
  logic [6:0]      q_bl_i = '0;
`ifdef MONTGOMERY_TAG_EN
  logic [7:0]      tag_o;
`endif
  int checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  montgomery_reduce_stream dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .x_i(x_i), .q_i(q_i), .qinv_i(qinv_i), .q_bl_i(q_bl_i),
`ifdef MONTGOMERY_TAG_EN
    .tag_i(8'h00), .tag_o(tag_o),
`endif
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .err_o(err_o)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] modpow(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
    logic [127:0] r, bb;
    r = 1; bb = b % m;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * bb) % m;
      bb = (bb * bb) % m;
    end
    return r[63:0];
  endfunction

  // 2^-bl mod q via Fermat (all moduli used here are prime)
  function automatic logic [63:0] rinv_of(input logic [63:0] q, input int bl);
    logic [127:0] r;
    r = (128'd1 << bl) % q;
    return modpow(r[63:0], q - 64'd2, q);
  endfunction

  function automatic logic [63:0] mont_ref(input logic [127:0] x, input logic [63:0] q, input logic [63:0] rinv);
    logic [127:0] a;
    a = x % q;
    a = (a * rinv) % q;
    return a[63:0];
  endfunction

  task automatic tick(input logic v, input logic [127:0] x, input logic [63:0] q, input logic [63:0] qi,
                      input logic [6:0] bl, input logic rdy, output logic acc, output logic take);
    @(negedge clk_i);
    valid_i = v; x_i = x; q_i = q; qinv_i = qi; q_bl_i = bl; ready_i = rdy;
    #1;
    acc  = valid_i && ready_o;
    take = valid_o && ready_i;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid_o);
    if (valid_o !== 1'b0) failures++;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b exp 1", ready_o); end
    checks++; if (result_o !== '0) begin failures++; $display("FAIL reset_result: got %0d exp 0", result_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", err_o); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_latency;
    logic acc, take; int n;
    tick(1, 128'd100, 64'd17, 64'd15, 7'd5, 1, acc, take);
    checks++; if (!acc) begin failures++; $display("FAIL lat_accept: got %b exp 1", acc); end
    n = 0;
    do begin tick(0, '0, '0, '0, '0, 1, acc, take); n++; end while (!valid_o && n < 50);
    checks++; if (n != LAT) begin failures++; $display("FAIL lat_cycles: got %0d exp %0d", n, LAT); end
    checks++; if (result_o !== 64'd1 || err_o !== 1'b0) begin
      failures++; $display("FAIL lat_result: got %0d/%b exp 1/0", result_o, err_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] xs[3]; logic [63:0] qs[3], qis[3], ex[3]; logic [6:0] bs[3];
    int tc[3]; int got; logic acc, take;
    xs = '{128'd543, 128'd50, 128'd0}; qs = '{64'd17, 64'd13, 64'd17};
    qis = '{64'd15, 64'd11, 64'd15}; bs = '{7'd5, 7'd4, 7'd5}; ex = '{64'd9, 64'd8, 64'd0};
    tc = '{0, 0, 0}; got = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1, xs[i], qs[i], qis[i], bs[i], 1, acc, take);
      checks++; if (!acc) begin failures++; $display("FAIL b2b_accept%0d: got 0 exp 1", i); end
    end
    for (int c = 0; c < 40 && got < 3; c++) begin
      tick(0, '0, '0, '0, '0, 1, acc, take);
      if (take) begin
        checks++; if (result_o !== ex[got] || err_o !== 1'b0) begin
          failures++; $display("FAIL b2b_result%0d: got %0d/%b exp %0d/0", got, result_o, err_o, ex[got]);
        end
        tc[got] = c; got++;
      end
    end
    checks++; if (got != 3 || tc[2] - tc[0] != 2) begin
      failures++; $display("FAIL b2b_consecutive: got %0d beats span %0d exp 3 beats span 2", got, tc[2] - tc[0]);
    end
  endtask

  task automatic test_illegal_bl;
    logic [127:0] xs[4]; logic [63:0] qs[4], qis[4], ex[4]; logic [6:0] bs[4]; logic ee[4];
    int got; logic acc, take;
    xs = '{128'd100, 128'd100, 128'd543, 128'd50}; qs = '{64'd17, 64'd17, 64'd17, 64'd13};
    qis = '{64'd15, 64'd15, 64'd15, 64'd11}; bs = '{7'd5, 7'd0, 7'd5, 7'd65};
    ex = '{64'd1, 64'd0, 64'd9, 64'd0}; ee = '{1'b0, 1'b1, 1'b0, 1'b1};
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick(c < 4, (c < 4) ? xs[c] : '0, (c < 4) ? qs[c] : '0, (c < 4) ? qis[c] : '0,
           (c < 4) ? bs[c] : '0, 1, acc, take);
      if (take) begin
        checks++; if (result_o !== ex[got] || err_o !== ee[got]) begin
          failures++; $display("FAIL illegal_bl%0d: got %0d/%b exp %0d/%b", got, result_o, err_o, ex[got], ee[got]);
        end
        got++;
      end
    end
    checks++; if (got != 4) begin failures++; $display("FAIL illegal_count: got %0d exp 4", got); end
  endtask

  task automatic test_random_stall;
    localparam int N = 20;
    logic [127:0] xs[N]; logic [63:0] qs[N], qis[N], ex[N]; logic [6:0] bs[N];
    logic [63:0] rv17, rv13, held_r; logic held_e, stalled, acc, take, v;
    int sent, got, extra;
    rv17 = rinv_of(64'd17, 5); rv13 = rinv_of(64'd13, 4);
    for (int i = 0; i < N; i++) begin
      qs[i]  = (i % 2 == 0) ? 64'd17 : 64'd13;
      qis[i] = (i % 2 == 0) ? 64'd15 : 64'd11;
      bs[i]  = (i % 2 == 0) ? 7'd5 : 7'd4;
      xs[i]  = 128'($urandom_range(0, (i % 2 == 0) ? 17 * 32 - 1 : 13 * 16 - 1));
      ex[i]  = mont_ref(xs[i], qs[i], (i % 2 == 0) ? rv17 : rv13);
    end
    sent = 0; got = 0; stalled = 0; held_r = '0; held_e = 0;
    for (int c = 0; c < 2000 && got < N; c++) begin
      v = (sent < N) && ($urandom_range(0, 3) != 0);
      tick(v, xs[sent % N], qs[sent % N], qis[sent % N], bs[sent % N], 1'($urandom_range(0, 1)), acc, take);
      checks++; if (ready_o !== (!valid_o || ready_i)) begin
        failures++; $display("FAIL stall_ready: got %b exp %b", ready_o, !valid_o || ready_i);
      end
      if (stalled) begin
        checks++; if (valid_o !== 1'b1 || result_o !== held_r || err_o !== held_e) begin
          failures++; $display("FAIL stall_hold: got %b/%0d exp 1/%0d", valid_o, result_o, held_r);
        end
      end
      if (take) begin
        checks++; if (result_o !== ex[got] || err_o !== 1'b0) begin
          failures++; $display("FAIL stall_beat%0d: got %0d exp %0d", got, result_o, ex[got]);
        end
        got++;
      end
      if (acc) sent++;
      stalled = valid_o && !ready_i; held_r = result_o; held_e = err_o;
    end
    extra = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      tick(0, '0, '0, '0, '0, 1, acc, take);
      if (take) extra++;
    end
    checks++; if (got != N || sent != N || extra != 0) begin
      failures++; $display("FAIL stall_count: got %0d sent %0d extra %0d exp %0d %0d 0", got, sent, extra, N, N);
    end
  endtask

  task automatic test_full_width;
    localparam int N = 1000;
    logic [63:0] q, qi, inv, rv, hi, lo, e; logic [127:0] x; logic acc, take;
    logic [63:0] expq[$]; int sent, got;
    q = 64'hFFFF_FFFF_FFFF_FFC5;
    inv = q;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - q * inv);
    qi = -inv;
    rv = rinv_of(q, 64);
    sent = 0; got = 0;
    hi = {$urandom, $urandom}; lo = {$urandom, $urandom};
    if (hi >= q) hi = hi - q;
    for (int c = 0; c < 5000 && got < N; c++) begin
      x = {hi, lo};
      tick(sent < N, x, q, qi, 7'd64, $urandom_range(0, 7) != 0, acc, take);
      if (take) begin
        e = (expq.size() > 0) ? expq.pop_front() : '0;
        checks++; if (result_o !== e || err_o !== 1'b0) begin
          failures++; $display("FAIL full_width%0d: got %h/%b exp %h/0", got, result_o, err_o, e);
        end
        got++;
      end
      if (acc) begin
        expq.push_back(mont_ref(x, q, rv));
        sent++;
        hi = {$urandom, $urandom}; lo = {$urandom, $urandom};
        if (hi >= q) hi = hi - q;
      end
    end
    checks++; if (got != N) begin failures++; $display("FAIL full_width_count: got %0d exp %0d", got, N); end
  endtask

  task automatic test_reset_midstream;
    logic acc, take; int n, seen;
    for (int i = 0; i < 5; i++) tick(1, 128'(100 + i), 64'd17, 64'd15, 7'd5, 0, acc, take);
    n = 0;
    do begin tick(0, '0, '0, '0, '0, 0, acc, take); n++; end while (!valid_o && n < 50);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL rst_fill: got %b exp 1", valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_async: got valid %b ready %b exp 0 1", valid_o, ready_o);
    end
    checks++; if (result_o !== '0 || err_o !== 1'b0) begin
      failures++; $display("FAIL rst_outputs: got %0d/%b exp 0/0", result_o, err_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    seen = 0;
    for (int c = 0; c < 3 * LAT; c++) begin
      tick(0, '0, '0, '0, '0, 1, acc, take);
      if (valid_o) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rst_stale: got %0d beats exp 0", seen); end
    tick(1, 128'd543, 64'd17, 64'd15, 7'd5, 1, acc, take);
    n = 0;
    do begin tick(0, '0, '0, '0, '0, 1, acc, take); n++; end while (!valid_o && n < 50);
    checks++; if (n != LAT || result_o !== 64'd9 || err_o !== 1'b0) begin
      failures++; $display("FAIL rst_new_beat: got lat %0d res %0d exp lat %0d res 9", n, result_o, LAT);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_back_to_back;
    test_illegal_bl;
    test_random_stall;
    test_full_width;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
